add_16: RTL and testbench

//   16-bit binary adder with carry-in and carry-out and a single registered output stage.

---
 rtl/add16_pkg.sv | 28 ++
 rtl/add_16_cla4.sv | 38 +++
 rtl/add_16.sv | 61 ++++++
 tb/tb_add_16.sv | 123 ++++++++++++
 4 files changed

// File: rtl/add16_pkg.sv
// Shared constants, result type and slice-level carry lookahead for the 16-bit adder.
package add16_pkg;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] sum;
    } result_t;

    // Slice carries: c[i+1] = G_i | P_i & c[i], with c[0] = cin.
    function automatic logic [NSLICE:0] lookahead(
        input logic [NSLICE-1:0] g,
        input logic [NSLICE-1:0] p,
        input logic              cin
    );
        logic [NSLICE:0] c;
        // NOTE: blocking assignments here, because each carry must see the one computed just before it.
        c[0] = cin;
        for (int i = 0; i < NSLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/add_16_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus group generate/propagate for the next level.
module cla4
    import add16_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             g,
    output logic             p
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Internal carries are fully expanded so no bit waits on a ripple.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign w_c[4] = g | (p & ci);

    assign s = w_p ^ w_c[SLICE-1:0];

    // Group terms do not depend on ci, which keeps the inter-slice path short.
    assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign p = &w_p;

    logic w_unused;
    assign w_unused = w_c[4];

endmodule

// File: rtl/add_16.sv
// 16-bit adder: four CLA slices, slice-level lookahead, one registered output stage.
module add_16
    import add16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic             cout,
    output logic [WIDTH-1:0] sum
);

    logic [NSLICE-1:0] w_g;
    logic [NSLICE-1:0] w_p;
    logic [NSLICE:0]   w_c;
    logic [WIDTH-1:0]  w_sum;
    result_t           w_next;
    result_t           r_res;
    logic              r_valid;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        cla4 u_cla4 (
            .a  (a[gi*SLICE +: SLICE]),
            .b  (b[gi*SLICE +: SLICE]),
            .ci (w_c[gi]),
            .s  (w_sum[gi*SLICE +: SLICE]),
            .g  (w_g[gi]),
            .p  (w_p[gi])
        );
    end

    assign w_c = lookahead(w_g, w_p, cin);

    always_comb begin
        // NOTE: default first so every path assigns the struct and no latch is inferred.
        w_next = r_res;
        if (in_valid) begin
            w_next.sum  = w_sum;
            w_next.cout = w_c[NSLICE];
        end
    end

    // NOTE: non-blocking for all state; reset clears the result register too so outputs are defined at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_res   <= w_next;
            r_valid <= in_valid;
        end
    end

    assign out_valid = r_valid;
    assign cout      = r_res.cout;
    assign sum       = r_res.sum;

endmodule

// File: tb/tb_add_16.sv
// Randomized bench for add_16 against an arithmetic model of {cout,sum} = a + b + cin.
module tb_add_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        cout;
    logic [15:0] sum;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: result of the last accepted operands, and whether the last edge issued.
    logic [16:0] m_res   = '0;
    logic        m_valid = 1'b0;

    add_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .cout      (cout),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sum"},   {16'h0, sum},       {16'h0, m_res[15:0]});
        check({tag, ".cout"},  {31'h0, cout},      {31'h0, m_res[16]});
        check({tag, ".valid"}, {31'h0, out_valid}, {31'h0, m_valid});
    endtask

    // Drive after a falling edge, let one rising edge capture, check at the next falling edge.
    task automatic step(input string tag, input logic v, input logic [15:0] ta,
                        input logic [15:0] tb, input logic tc);
        in_valid = v;
        a        = ta;
        b        = tb;
        cin      = tc;
        @(posedge clk);
        m_valid = v;
        if (v) m_res = {1'b0, ta} + {1'b0, tb} + {16'h0, tc};
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        #1;
        check_outputs("reset_async");
        repeat (2) @(negedge clk);
        check_outputs("reset_held");
        rst_n = 1'b1;

        step("add_1_1",    1'b1, 16'h0001, 16'h0001, 1'b0);
        check("add_1_1.lit", {15'h0, cout, sum}, 32'h0000_0002);
        step("add_1_1_c",  1'b1, 16'h0001, 16'h0001, 1'b1);
        check("add_1_1_c.lit", {15'h0, cout, sum}, 32'h0000_0003);
        step("add_a_3_c",  1'b1, 16'h000a, 16'h0003, 1'b1);
        check("add_a_3_c.lit", {15'h0, cout, sum}, 32'h0000_000e);

        step("slice_carry", 1'b1, 16'h000f, 16'h0000, 1'b1);
        check("slice_carry.lit", {15'h0, cout, sum}, 32'h0000_0010);
        step("wrap",        1'b1, 16'hffff, 16'h0001, 1'b0);
        check("wrap.lit", {15'h0, cout, sum}, 32'h0001_0000);
        step("add_10_20_c", 1'b1, 16'h0010, 16'h0020, 1'b1);
        check("add_10_20_c.lit", {15'h0, cout, sum}, 32'h0000_0031);

        step("max",  1'b1, 16'hffff, 16'hffff, 1'b1);
        check("max.lit", {15'h0, cout, sum}, 32'h0001_ffff);
        step("zero", 1'b1, 16'h0000, 16'h0000, 1'b0);
        check("zero.lit", {15'h0, cout, sum}, 32'h0000_0000);

        step("issue_5555", 1'b1, 16'h1234, 16'h4321, 1'b0);
        check("issue_5555.lit", {15'h0, out_valid, sum}, 32'h0001_5555);
        step("hold_5555",  1'b0, 16'h9999, 16'h7777, 1'b1);
        check("hold_5555.lit", {15'h0, out_valid, sum}, 32'h0000_5555);

        // Mid-stream reset between edges during back-to-back adds.
        step("pre_rst_0", 1'b1, 16'h8000, 16'h8000, 1'b1);
        step("pre_rst_1", 1'b1, 16'h7fff, 16'h0001, 1'b0);
        #2;
        rst_n = 1'b0;
        m_res   = '0;
        m_valid = 1'b0;
        #1;
        check_outputs("mid_rst");
        @(negedge clk);
        check_outputs("mid_rst_held");
        rst_n = 1'b1;
        step("post_rst", 1'b1, 16'hbeef, 16'h1111, 1'b1);
        check("post_rst.lit", {15'h0, cout, sum}, 32'h0000_d001);

        for (int i = 0; i < 10000; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
